// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed driver for a row of common-anode 7-segment digits. Each
// digit is driven for SCAN_DIV clock cycles in turn, 0 up to DIGITS-1. New
// display data is staged in a pending register and only moves to the active
// register at the frame wrap, so a single frame never mixes old and new data.
//
// Parameters
//   DIGITS    number of multiplexed digits (1..8)
//   SCAN_DIV  clock cycles each digit is driven (>= 1)
//   HEX_EN    1: nibbles 10..15 show A..F, 0: they are blanked
//   LZ_BLANK  1: leading zeros are blanked (digit 0 is always shown)
//
// Ports
//   clk         sole clock, rising edge
//   rst_N       asynchronous active-low reset
//   number      packed nibbles, digit 0 in [3:0]
//   dp_in       decimal-point request per digit, 1 = lit
//   load        1-cycle strobe capturing number and dp_in
//   pin_out     segments {g,f,e,d,c,b,a}, active-low
//   dp_out      decimal point, active-low
//   dig_sel     digit enables, active-low, exactly one low after reset
//   frame_done  1-cycle pulse after each completed scan frame
// ---------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int HEX_EN   = 1,
  parameter int LZ_BLANK = 1
) (
  input  logic                  clk,
  input  logic                  rst_N,
  input  logic [4*DIGITS-1:0]   number,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  output logic [6:0]            pin_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_done
);

  // Counters need at least one bit even when they only ever hold zero.
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] pendNum_q, pendNum_d;
  logic [DIGITS-1:0]   pendDp_q, pendDp_d;
  logic [4*DIGITS-1:0] actNum_q, actNum_d;
  logic [DIGITS-1:0]   actDp_q, actDp_d;
  logic [6:0]          pin_q, pin_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                fd_q, fd_d;

  logic                digitEnd;
  logic                wrap;
  logic [3:0]          curNib;
  logic                curDp;
  logic                curBlank;
  logic                allZero;
  logic [DIGITS-1:0]   blankMask;

  // Nibble to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] segDecode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    if ((HEX_EN == 0) && (v > 4'd9)) begin
      s = SEG_BLANK;
    end
    return s;
  endfunction

  always_comb begin
    digitEnd = (cnt_q == CNT_MAX);
    wrap     = digitEnd && (idx_q == IDX_MAX);

    cnt_d = digitEnd ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (digitEnd) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    // A load on the wrap edge goes straight through to the active copy,
    // because the active register takes the pending register's next value.
    pendNum_d = load ? number : pendNum_q;
    pendDp_d  = load ? dp_in  : pendDp_q;
    actNum_d  = wrap ? pendNum_d : actNum_q;
    actDp_d   = wrap ? pendDp_d  : actDp_q;

    // Walk from the top digit down: a digit is a leading zero when it and
    // every digit above it are zero. Digit 0 always shows its value.
    allZero   = 1'b1;
    blankMask = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      allZero      = allZero && (actNum_q[4*k +: 4] == 4'd0);
      blankMask[k] = allZero && (k != 0) && (LZ_BLANK != 0);
    end

    curNib   = '0;
    curDp    = 1'b0;
    curBlank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        curNib   = actNum_q[4*k +: 4];
        curDp    = actDp_q[k];
        curBlank = blankMask[k];
      end
    end

    // Outputs reflect the digit index held before this edge.
    pin_d = curBlank ? SEG_BLANK : segDecode(curNib);
    dp_d  = ~curDp;
    sel_d = ~(DIGITS'(1) << idx_q);
    fd_d  = wrap;
  end

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      pendNum_q <= '0;
      pendDp_q  <= '0;
      actNum_q  <= '0;
      actDp_q   <= '0;
      pin_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
      sel_q     <= '1;
      fd_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pendNum_q <= pendNum_d;
      pendDp_q  <= pendDp_d;
      actNum_q  <= actNum_d;
      actDp_q   <= actDp_d;
      pin_q     <= pin_d;
      dp_q      <= dp_d;
      sel_q     <= sel_d;
      fd_q      <= fd_d;
    end
  end

  assign pin_out    = pin_q;
  assign dp_out     = dp_q;
  assign dig_sel    = sel_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Four driver instances share one stimulus stream:
//   0: DIGITS=4 SCAN_DIV=4 HEX_EN=1 LZ_BLANK=1
//   1: DIGITS=4 SCAN_DIV=4 HEX_EN=0 LZ_BLANK=0
//   2: DIGITS=3 SCAN_DIV=1 HEX_EN=1 LZ_BLANK=1
//   3: DIGITS=1 SCAN_DIV=3 HEX_EN=1 LZ_BLANK=1
// The reference model describes the display in terms of "cycles since reset
// release": edge t shows digit (t / SCAN_DIV) % DIGITS of the value latched at
// the most recent frame boundary, and frame_done follows the last edge of a
// frame.
// ---------------------------------------------------------------------------
module tb_seg_scan_driver;

  typedef struct packed {
    logic [6:0] pin;
    logic       dp;
    logic [7:0] sel;
    logic       fd;
  } exp_t;

  typedef exp_t [3:0] bundle_t;

  logic        clk = 1'b0;
  logic        rst_N;
  logic [15:0] number;
  logic [3:0]  dp_in;
  logic        load;

  logic [6:0] pinA, pinB, pinC, pinD;
  logic       dpA, dpB, dpC, dpD;
  logic [3:0] selA, selB;
  logic [2:0] selC;
  logic [0:0] selD;
  logic       fdA, fdB, fdC, fdD;

  logic [6:0] actPin[4];
  logic       actDp[4];
  logic [7:0] actSel[4];
  logic       actFd[4];

  int tests = 0;
  int fails = 0;

  // Model state
  int          t;
  logic [31:0] pendNum;
  logic [7:0]  pendDp;
  logic [31:0] shownNum[4];
  logic [7:0]  shownDp[4];
  bundle_t     expQ[$];
  logic [6:0]  segTable[16];

  always #5 clk = ~clk;

  seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .HEX_EN(1), .LZ_BLANK(1)) dutA (
    .clk(clk), .rst_N(rst_N), .number(number), .dp_in(dp_in), .load(load),
    .pin_out(pinA), .dp_out(dpA), .dig_sel(selA), .frame_done(fdA));

  seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .HEX_EN(0), .LZ_BLANK(0)) dutB (
    .clk(clk), .rst_N(rst_N), .number(number), .dp_in(dp_in), .load(load),
    .pin_out(pinB), .dp_out(dpB), .dig_sel(selB), .frame_done(fdB));

  seg_scan_driver #(.DIGITS(3), .SCAN_DIV(1), .HEX_EN(1), .LZ_BLANK(1)) dutC (
    .clk(clk), .rst_N(rst_N), .number(number[11:0]), .dp_in(dp_in[2:0]), .load(load),
    .pin_out(pinC), .dp_out(dpC), .dig_sel(selC), .frame_done(fdC));

  seg_scan_driver #(.DIGITS(1), .SCAN_DIV(3), .HEX_EN(1), .LZ_BLANK(1)) dutD (
    .clk(clk), .rst_N(rst_N), .number(number[3:0]), .dp_in(dp_in[0:0]), .load(load),
    .pin_out(pinD), .dp_out(dpD), .dig_sel(selD), .frame_done(fdD));

  assign actPin[0] = pinA;
  assign actPin[1] = pinB;
  assign actPin[2] = pinC;
  assign actPin[3] = pinD;
  assign actDp[0]  = dpA;
  assign actDp[1]  = dpB;
  assign actDp[2]  = dpC;
  assign actDp[3]  = dpD;
  assign actSel[0] = {4'b0, selA};
  assign actSel[1] = {4'b0, selB};
  assign actSel[2] = {5'b0, selC};
  assign actSel[3] = {7'b0, selD};
  assign actFd[0]  = fdA;
  assign actFd[1]  = fdB;
  assign actFd[2]  = fdC;
  assign actFd[3]  = fdD;

  // Segment patterns for each nibble, active-low {g,f,e,d,c,b,a}.
  initial begin
    segTable[0]  = 7'b1000000;
    segTable[1]  = 7'b1111001;
    segTable[2]  = 7'b0100100;
    segTable[3]  = 7'b0110000;
    segTable[4]  = 7'b0011001;
    segTable[5]  = 7'b0010010;
    segTable[6]  = 7'b0000010;
    segTable[7]  = 7'b1111000;
    segTable[8]  = 7'b0000000;
    segTable[9]  = 7'b0010000;
    segTable[10] = 7'b0001000;
    segTable[11] = 7'b0000011;
    segTable[12] = 7'b1000110;
    segTable[13] = 7'b0100001;
    segTable[14] = 7'b0000110;
    segTable[15] = 7'b0001110;
  end

  function automatic int cfgDigits(input int i);
    case (i)
      2:       return 3;
      3:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int cfgDiv(input int i);
    case (i)
      2:       return 1;
      3:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic bit cfgHex(input int i);
    return (i != 1);
  endfunction

  function automatic bit cfgLz(input int i);
    return (i != 1);
  endfunction

  function automatic int frameLen(input int i);
    return cfgDigits(i) * cfgDiv(i);
  endfunction

  function automatic logic [7:0] allOnes(input int d);
    return 8'((1 << d) - 1);
  endfunction

  // What instance i shows on the t-th edge after reset release.
  function automatic exp_t expectFor(input int i, input int tt,
                                     input logic [31:0] num, input logic [7:0] dpv);
    exp_t        e;
    int          d;
    int          k;
    int          nib;
    logic [31:0] val;
    d   = cfgDigits(i);
    k   = (tt / cfgDiv(i)) % d;
    val = num & ((32'd1 << (4 * d)) - 32'd1);
    nib = int'((val >> (4 * k)) & 32'hF);
    if (cfgLz(i) && (k > 0) && ((val >> (4 * k)) == 32'd0))
      e.pin = 7'b1111111;
    else if (!cfgHex(i) && (nib > 9))
      e.pin = 7'b1111111;
    else
      e.pin = segTable[nib];
    e.dp  = ~dpv[k];
    e.sel = allOnes(d) & ~(8'd1 << k);
    e.fd  = ((tt % frameLen(i)) == frameLen(i) - 1);
    return e;
  endfunction

  task automatic checkOutput(input string name, input int inst,
                             input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s inst%0d at %0t: got %h, want %h", name, inst, $time, act, expv);
    end
  endtask

  task automatic checkReset();
    for (int i = 0; i < 4; i++) begin
      checkOutput("rstPin", i, 32'(actPin[i]), 32'h7F);
      checkOutput("rstDp", i, 32'(actDp[i]), 32'h1);
      checkOutput("rstSel", i, 32'(actSel[i]), 32'(allOnes(cfgDigits(i))));
      checkOutput("rstFd", i, 32'(actFd[i]), 32'h0);
    end
  endtask

  // One clock of stimulus: drive inputs at the falling edge and queue what
  // every instance must show after the following rising edge.
  task automatic applyStimulus(input logic ld, input logic [15:0] num, input logic [3:0] dpv);
    bundle_t b;
    @(negedge clk);
    load   = ld;
    number = num;
    dp_in  = dpv;
    if (rst_N) begin
      for (int i = 0; i < 4; i++) begin
        b[i] = expectFor(i, t, shownNum[i], shownDp[i]);
      end
      expQ.push_back(b);
      if (ld) begin
        pendNum = {16'h0, num};
        pendDp  = {4'h0, dpv};
      end
      for (int i = 0; i < 4; i++) begin
        if ((t % frameLen(i)) == frameLen(i) - 1) begin
          shownNum[i] = pendNum;
          shownDp[i]  = pendDp;
        end
      end
      t++;
    end
  endtask

  task automatic runIdle(input int n);
    for (int c = 0; c < n; c++) begin
      applyStimulus(1'b0, 16'($urandom), 4'($urandom));
    end
  endtask

  // Idle until the next edge is at position p within instance 0's frame.
  task automatic waitPhase(input int p);
    for (int c = 0; c < 32; c++) begin
      if ((t % 16) == p) break;
      applyStimulus(1'b0, 16'($urandom), 4'($urandom));
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_N = 1'b0;
    load  = 1'b0;
    #1;
    checkReset();
    t       = 0;
    pendNum = '0;
    pendDp  = '0;
    for (int i = 0; i < 4; i++) begin
      shownNum[i] = '0;
      shownDp[i]  = '0;
    end
    expQ.delete();
    repeat (2) @(negedge clk);
    #1;
    checkReset();
    @(posedge clk);
    #2;
    rst_N = 1'b1;
  endtask

  // Monitor: just after every rising edge, compare all instances against the
  // oldest queued expectation.
  initial begin : monitor
    bundle_t got;
    forever begin
      @(posedge clk);
      #1;
      if (rst_N && (expQ.size() > 0)) begin
        got = expQ.pop_front();
        for (int i = 0; i < 4; i++) begin
          checkOutput("pin_out", i, 32'(actPin[i]), 32'(got[i].pin));
          checkOutput("dp_out", i, 32'(actDp[i]), 32'(got[i].dp));
          checkOutput("dig_sel", i, 32'(actSel[i]), 32'(got[i].sel));
          checkOutput("frame_done", i, 32'(actFd[i]), 32'(got[i].fd));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  // Stimulus: directed display patterns first, then random loads and a
  // random mid-run reset.
  initial begin : stimulus
    logic [15:0] mask;
    int          resetAt;
    rst_N  = 1'b0;
    load   = 1'b0;
    number = '0;
    dp_in  = '0;
    doReset();
    runIdle(20);

    applyStimulus(1'b1, 16'h1234, 4'b0000);
    runIdle(40);

    applyStimulus(1'b1, 16'h0050, 4'b0100);
    runIdle(40);

    applyStimulus(1'b1, 16'hABCF, 4'b1001);
    runIdle(36);

    // Mid-frame load must not disturb the frame in progress.
    waitPhase(6);
    applyStimulus(1'b1, 16'h9999, 4'b0010);
    runIdle(30);

    // Load on the wrap edge shows up in the very next frame.
    waitPhase(15);
    applyStimulus(1'b1, 16'h5A3C, 4'b1000);
    runIdle(20);

    // Reset mid-frame discards both the shown and the pending data.
    waitPhase(3);
    applyStimulus(1'b1, 16'h7777, 4'b1111);
    runIdle(3);
    doReset();
    runIdle(24);

    resetAt = 200 + int'($urandom_range(0, 100));
    for (int c = 0; c < 600; c++) begin
      if (c == resetAt) begin
        doReset();
      end
      case ($urandom_range(0, 3))
        0:       mask = 16'h000F;
        1:       mask = 16'h00FF;
        2:       mask = 16'h0FFF;
        default: mask = 16'hFFFF;
      endcase
      applyStimulus(($urandom_range(0, 7) == 0), 16'($urandom) & mask, 4'($urandom));
    end

    @(posedge clk);
    #2;
    checkOutput("queueDrain", 0, 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
